cry_pattern_gen: RTL and testbench

CRY_PATTERN_GEN -- requirements
Module: cry_pattern_gen

---
 rtl/cry_pattern_gen.sv | 105 ++++++++++
 tb/tb_cry_pattern_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cry_pattern_gen.sv
// Serial "cry" pattern generator: emits reps bursts of 1,0,1 each followed by GAP idle cycles.
// All outputs are registered; abort ends an active transmission with a one-cycle aborted pulse.
module cry_pattern_gen #(
  parameter int unsigned GAP   = 2,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] sent
);

  typedef enum logic [2:0] {
    StIdle,
    StBitA,
    StBitB,
    StBitC,
    StGap
  } state_e;

  localparam logic [3:0] GapLast = 4'(GAP - 1);

  state_e           state_q;
  logic [3:0]       gap_cnt_q;
  logic [CNT_W-1:0] reps_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      gap_cnt_q <= '0;
      reps_q    <= '0;
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      sent      <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state_q != StIdle && abort) begin
        // sent keeps the count of bursts finished before the abort
        state_q <= StIdle;
        out     <= 1'b0;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !abort) begin
              sent <= '0;
              if (reps == '0) begin
                done <= 1'b1;
              end else begin
                state_q <= StBitA;
                reps_q  <= reps;
                out     <= 1'b1;
                busy    <= 1'b1;
              end
            end
          end
          StBitA: begin
            state_q <= StBitB;
            out     <= 1'b0;
          end
          StBitB: begin
            state_q <= StBitC;
            out     <= 1'b1;
          end
          StBitC: begin
            state_q   <= StGap;
            out       <= 1'b0;
            gap_cnt_q <= '0;
            sent      <= sent + CNT_W'(1);
          end
          StGap: begin
            if (gap_cnt_q == GapLast) begin
              if (sent < reps_q) begin
                state_q <= StBitA;
                out     <= 1'b1;
              end else begin
                state_q <= StIdle;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q + 4'd1;
            end
          end
          default: begin
            state_q <= StIdle;
            out     <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cry_pattern_gen.sv
// Bench for cry_pattern_gen: directed scenarios plus random traffic against a queue-based
// model that expands each accepted request into its full expected output timeline.
module tb_cry_pattern_gen;

  localparam int unsigned GAP   = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned Per   = 3 + GAP;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] reps = '0;
  logic             out, busy, done, aborted;
  logic [CNT_W-1:0] sent;

  cry_pattern_gen #(
    .GAP  (GAP),
    .CNT_W(CNT_W)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .reps   (reps),
    .abort  (abort),
    .out    (out),
    .busy   (busy),
    .done   (done),
    .aborted(aborted),
    .sent   (sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             o;
    logic             b;
    logic             d;
    logic             a;
    logic [CNT_W-1:0] s;
  } exp_t;

  exp_t cur;
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   det_cnt = 0;
  int   done_cnt = 0;
  int   busy_cyc = 0;
  logic [2:0] det_sh = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, " out"}, 32'(out), 32'(cur.o));
    check_val({tag, " busy"}, 32'(busy), 32'(cur.b));
    check_val({tag, " done"}, 32'(done), 32'(cur.d));
    check_val({tag, " aborted"}, 32'(aborted), 32'(cur.a));
    check_val({tag, " sent"}, 32'(sent), 32'(cur.s));
  endtask

  function automatic exp_t mk(logic o, logic b, logic d, logic a, logic [CNT_W-1:0] s);
    exp_t e;
    e.o = o; e.b = b; e.d = d; e.a = a; e.s = s;
    return e;
  endfunction

  // Advance the model by one rising edge given the inputs that edge sampled.
  function automatic void model_edge(logic st, logic [CNT_W-1:0] rp, logic ab);
    exp_t nxt;
    if (cur.b && ab) begin
      exp_q.delete();
      nxt = mk(1'b0, 1'b0, 1'b0, 1'b1, cur.s);
    end else if (exp_q.size() != 0) begin
      nxt = exp_q.pop_front();
    end else begin
      nxt = mk(1'b0, 1'b0, 1'b0, 1'b0, cur.s);
      if (st && !ab) begin
        if (rp == '0) begin
          nxt = mk(1'b0, 1'b0, 1'b1, 1'b0, '0);
        end else begin
          for (int k = 0; k < int'(rp) * int'(Per); k++) begin
            int pos;
            int bursts_done;
            pos = k % int'(Per);
            bursts_done = k / int'(Per) + ((pos >= 3) ? 1 : 0);
            exp_q.push_back(mk((pos == 0 || pos == 2), 1'b1, 1'b0, 1'b0, CNT_W'(bursts_done)));
          end
          exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, rp));
          nxt = exp_q.pop_front();
        end
      end
    end
    cur = nxt;
  endfunction

  task automatic step(input string tag, input logic st, input logic [CNT_W-1:0] rp,
                      input logic ab);
    start = st;
    reps  = rp;
    abort = ab;
    @(posedge clk);
    model_edge(st, rp, ab);
    #1;
    det_sh = {det_sh[1:0], out};
    if (det_sh == 3'b101) det_cnt++;
    if (done) done_cnt++;
    if (busy) busy_cyc++;
    check_all(tag);
  endtask

  initial begin
    cur = mk(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #12;
    check_all("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Start accepted on the very first edge after reset release; two bursts.
    done_cnt = 0;
    busy_cyc = 0;
    step("two_bursts", 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 12; i++) step("two_bursts", 1'b0, 4'd0, 1'b0);
    check_val("two_bursts busy_cycles", 32'(busy_cyc), 32'(2 * Per));
    check_val("two_bursts done_count", 32'(done_cnt), 32'd1);

    // Zero reps completes immediately.
    step("zero_reps", 1'b1, 4'd0, 1'b0);
    step("zero_reps", 1'b0, 4'd0, 1'b0);

    // Abort in the second burst's BIT_B.
    done_cnt = 0;
    step("abort", 1'b1, 4'd3, 1'b0);
    for (int i = 0; i < 6; i++) step("abort", 1'b0, 4'd0, 1'b0);
    check_val("abort pre_out", 32'(out), 32'd0);
    step("abort", 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) step("abort", 1'b0, 4'd0, 1'b0);
    check_val("abort done_count", 32'(done_cnt), 32'd0);

    // Abort and start together in IDLE: nothing happens.
    step("abort_idle", 1'b1, 4'd3, 1'b1);
    step("abort_idle", 1'b0, 4'd0, 1'b0);

    // start/reps toggled during a transmission are ignored.
    done_cnt = 0;
    step("busy_start", 1'b1, 4'd4, 1'b0);
    for (int i = 0; i < 19; i++) step("busy_start", 1'b1, CNT_W'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) step("busy_start", 1'b0, 4'd0, 1'b0);
    check_val("busy_start done_count", 32'(done_cnt), 32'd1);

    // Detector sees exactly one 1-0-1 per burst.
    det_cnt = 0;
    step("detect", 1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 27; i++) step("detect", 1'b0, 4'd0, 1'b0);
    check_val("detect count", 32'(det_cnt), 32'd5);

    // Maximum reps must not wrap sent.
    step("max_reps", 1'b1, 4'd15, 1'b0);
    for (int i = 0; i < 77; i++) step("max_reps", 1'b0, 4'd0, 1'b0);

    // Asynchronous reset in BIT_C.
    done_cnt = 0;
    step("async_rst", 1'b1, 4'd2, 1'b0);
    step("async_rst", 1'b0, 4'd0, 1'b0);
    step("async_rst", 1'b0, 4'd0, 1'b0);
    check_val("async_rst in_bit_c", 32'(out), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_val("async_rst out", 32'(out), 32'd0);
    check_val("async_rst busy", 32'(busy), 32'd0);
    check_val("async_rst sent", 32'(sent), 32'd0);
    exp_q.delete();
    cur = mk(1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    check_all("async_rst held");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) step("async_rst after", 1'b0, 4'd0, 1'b0);
    check_val("async_rst done_count", 32'(done_cnt), 32'd0);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      logic [CNT_W-1:0] rp;
      rp = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 4));
      step("random", ($urandom_range(0, 3) == 0), rp, ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global timeout guard.
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
